// File: rtl/store_pkg.sv
// Shared types and helpers for the store unit: FSM state, funct3 encodings,
// latched request payload and store legality checks.
package store_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        ERR
    } state_e;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Request fields kept for the multi-cycle read-modify-write path.
    typedef struct packed {
        logic [WORD_W-1:0] wdata;
        logic [2:0]        funct3;
        logic [1:0]        lane;
    } req_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_SH:   return addr_lo[0];
            F3_SW:   return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] funct3);
        return !((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Store request handshake plus word-wide data memory port.
interface store_unit_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  st_valid;
    logic                  st_ready;
    logic [31:0]           st_addr;
    logic [31:0]           st_wdata;
    logic [2:0]            st_funct3;
    logic                  st_done;
    logic                  st_err;
    logic                  mem_re;
    logic                  mem_we;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wd;
    logic [3:0]            mem_be;
    logic [DATA_W-1:0]     mem_rd;

    // Pipeline and memory side.
    modport master (
        output st_valid, st_addr, st_wdata, st_funct3, mem_rd,
        input  st_ready, st_done, st_err, mem_re, mem_we, mem_addr, mem_wd, mem_be
    );

    // Store unit side.
    modport slave (
        input  st_valid, st_addr, st_wdata, st_funct3, mem_rd,
        output st_ready, st_done, st_err, mem_re, mem_we, mem_addr, mem_wd, mem_be
    );
endinterface

// File: rtl/store_merge.sv
// Lane merge for sub-word stores: RMW-merged word, lane-replicated word and
// matching byte strobes, used by both the RMW and byte-strobe builds.
module store_merge
    import store_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [2:0]        funct3,
    input  logic [1:0]        lane,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] repl,
    output logic [BE_W-1:0]   be
);

    always_comb begin
        merged = old_word;
        repl   = wdata;
        be     = 4'hF;
        case (funct3)
            F3_SB: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                repl = {4{wdata[7:0]}};
                be   = 4'b0001 << lane;
            end
            F3_SH: begin
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                repl = {2{wdata[15:0]}};
                be   = 4'b0011 << {lane[1], 1'b0};
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: SB/SH/SW onto a word-wide data memory, with RMW for
// sub-word stores, or direct byte strobes when STORE_BYTE_STROBE_EN is defined.
module store_unit
    import store_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    store_unit_if.slave bus
);

`ifdef STORE_BYTE_STROBE_EN
    localparam bit BYTE_STROBE = 1'b1;
`else
    localparam bit BYTE_STROBE = 1'b0;
`endif

    state_e                state_q, state_n;
    req_t                  req_q, req_sel_c;
    logic                  mem_re_q, mem_re_n;
    logic                  mem_we_q, mem_we_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;
    logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0]     mem_wd_q, mem_wd_n;
    logic [BE_W-1:0]       mem_be_q, mem_be_n;
    logic                  st_ready_c, accept_c, bad_c;
    logic [WORD_W-1:0]     merged, repl;
    logic [BE_W-1:0]       lane_be;
    logic                  unused_addr_hi;

    // Upper address bits wrap away: memory only decodes DM_ADDRESS bits.
    assign unused_addr_hi = ^bus.st_addr[31:DM_ADDRESS];

    assign st_ready_c = (state_q == IDLE) && !reset;
    assign accept_c   = bus.st_valid && st_ready_c;
    assign bad_c      = is_illegal(bus.st_funct3) || is_misaligned(bus.st_funct3, bus.st_addr[1:0]);

    // In IDLE the merger sees the live request; afterwards the latched copy.
    always_comb begin
        req_sel_c = req_q;
        if (state_q == IDLE) begin
            req_sel_c.wdata  = bus.st_wdata;
            req_sel_c.funct3 = bus.st_funct3;
            req_sel_c.lane   = bus.st_addr[1:0];
        end
    end

    store_merge u_merge (
        .old_word (bus.mem_rd),
        .wdata    (req_sel_c.wdata),
        .funct3   (req_sel_c.funct3),
        .lane     (req_sel_c.lane),
        .merged   (merged),
        .repl     (repl),
        .be       (lane_be)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            mem_be_q   <= '1;
        end else begin
            state_q    <= state_n;
            mem_re_q   <= mem_re_n;
            mem_we_q   <= mem_we_n;
            done_q     <= done_n;
            err_q      <= err_n;
            mem_addr_q <= mem_addr_n;
            mem_wd_q   <= mem_wd_n;
            mem_be_q   <= mem_be_n;
            if (accept_c) begin
                req_q <= req_sel_c;
            end
        end
    end

    // Outputs are computed for the state being entered, so strobes are
    // registered and line up exactly with READ/WRITE/ERR.
    always_comb begin
        state_n    = state_q;
        mem_re_n   = 1'b0;
        mem_we_n   = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        mem_addr_n = mem_addr_q;
        mem_wd_n   = mem_wd_q;
        mem_be_n   = mem_be_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    mem_addr_n = {bus.st_addr[DM_ADDRESS-1:2], 2'b00};
                    if (bad_c) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end else if (BYTE_STROBE || (bus.st_funct3 == F3_SW)) begin
                        state_n  = WRITE;
                        mem_we_n = 1'b1;
                        done_n   = 1'b1;
                        mem_wd_n = BYTE_STROBE ? repl : merged;
                        mem_be_n = BYTE_STROBE ? lane_be : '1;
                    end else begin
                        state_n  = READ;
                        mem_re_n = 1'b1;
                    end
                end
            end
            READ: begin
                state_n = MERGE;
            end
            MERGE: begin
                state_n  = WRITE;
                mem_we_n = 1'b1;
                done_n   = 1'b1;
                mem_wd_n = merged;
                mem_be_n = '1;
            end
            WRITE:   state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.st_ready = st_ready_c;
    assign bus.st_done  = done_q;
    assign bus.st_err   = err_q;
    assign bus.mem_re   = mem_re_q;
    // A write in flight is suppressed the moment reset is raised.
    assign bus.mem_we   = mem_we_q && !reset;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign bus.mem_be   = mem_be_q;

endmodule
